// File: rtl/mig_fetch_pkg.sv
// Mig fetch unit: shared types, constants and helpers.
package mig_fetch_pkg;

  localparam int INSN_SIZE      = 4;
  localparam int INSN_WIDTH     = 32;
  localparam int INSN_SIZE_BITS = 2;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_e;

  typedef struct packed {
    logic [INSN_WIDTH-1:0]        insn;
    logic [31:INSN_SIZE_BITS]     pc;
  } fetch_entry_t;

  function automatic int unsigned byte_addr(
    input int unsigned word
  );
    return word * INSN_SIZE;
  endfunction

endpackage

// File: rtl/mig_fetch_if.sv
// Memory read port and decode handshake of the fetch unit.
interface mig_fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  import mig_fetch_pkg::*;

  logic                    mem_rd_en;
  logic [ADDR_WIDTH-3:0]   mem_rd_addr;
  logic                    mem_rd_valid;
  logic [INSN_WIDTH-1:0]   mem_rd_data;
  logic                    dec_valid;
  logic                    dec_ready;
  logic [INSN_WIDTH-1:0]   dec_insn;
  logic [ADDR_WIDTH-1:2]   dec_pc;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_valid, mem_rd_data,
    output dec_valid, dec_insn, dec_pc,
    input  dec_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_valid, mem_rd_data,
    input  dec_valid, dec_insn, dec_pc,
    output dec_ready
  );

endinterface

// File: rtl/mig_insn_queue.sv
// In-order FIFO with flush; holds fetched entries or request PCs.
module mig_insn_queue
  import mig_fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     wdata,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full queue accepts a push only when the head leaves together
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mig_fetch_unit.sv
// Mig instruction fetch front end: credit-limited issue, in-order
// instruction queue, redirect with squashing of in-flight responses.
module mig_fetch_unit
  import mig_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:2] rst_pc,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:2] redirect_pc,
  mig_fetch_if.master           bus
);

  localparam int CW = $clog2(QUEUE_DEPTH+1);

  typedef logic [ADDR_WIDTH-1:2] pc_t;
  typedef struct packed {
    logic [INSN_WIDTH-1:0] insn;
    pc_t                   pc;
  } entry_t;

  fetch_state_e  state, state_n;
  pc_t           fetch_pc, fetch_pc_n;
  logic [CW-1:0] live, live_n;
  logic [CW-1:0] stale, stale_n;
  logic [CW-1:0] count, sh_count;
  logic          issue, rsp, rsp_live;
  logic          redirect, deq;
  logic          q_empty, q_full;
  logic          sh_empty, sh_full;
  entry_t        q_head, q_wdata;
  pc_t           sh_head;

  assign redirect = redirect_valid && (state == RUN);
  assign issue    = (state == RUN) && fetch_en && !redirect_valid
                 && (({1'b0, count} + {1'b0, live})
                     < (CW+1)'(QUEUE_DEPTH));
  // a response with nothing outstanding is a protocol error; drop it
  assign rsp      = bus.mem_rd_valid && (live != '0 || stale != '0);
  assign rsp_live = rsp && (stale == '0);
  assign deq      = bus.dec_valid && bus.dec_ready;
  assign q_wdata  = '{insn: bus.mem_rd_data, pc: sh_head};

  mig_insn_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_live),
    .pop   (deq),
    .flush (redirect),
    .wdata (q_wdata),
    .head  (q_head),
    .count (count),
    .empty (q_empty),
    .full  (q_full)
  );

  // shadow of live request PCs; stale ones are already dead on redirect
  mig_insn_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (pc_t)
  ) u_pc_shadow (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (rsp_live),
    .flush (redirect),
    .wdata (fetch_pc),
    .head  (sh_head),
    .count (sh_count),
    .empty (sh_empty),
    .full  (sh_full)
  );

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    live_n     = live;
    stale_n    = stale;
    unique case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (redirect) begin
          fetch_pc_n = redirect_pc;
          stale_n    = stale + live - CW'(rsp);
          live_n     = '0;
        end else begin
          if (issue) fetch_pc_n = fetch_pc + 1'b1;
          live_n  = live + CW'(issue) - CW'(rsp_live);
          stale_n = stale - CW'(rsp && !rsp_live);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      fetch_pc <= rst_pc;
      live     <= '0;
      stale    <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      live     <= live_n;
      stale    <= stale_n;
    end
  end

  assign bus.mem_rd_en   = issue;
  assign bus.mem_rd_addr = fetch_pc;
  assign bus.dec_valid   = !q_empty;
  assign bus.dec_insn    = q_empty ? '0 : q_head.insn;
  assign bus.dec_pc      = q_empty ? '0 : q_head.pc;

  function automatic int unsigned public_get_fetch_PC();
    return byte_addr(32'(fetch_pc));
  endfunction

  a_no_orphan_rsp: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.mem_rd_valid && live == '0 && stale == '0));
  a_shadow_tracks_live: assert property (
    @(posedge clk) disable iff (rst) sh_count == live);
  a_push_has_room: assert property (
    @(posedge clk) disable iff (rst)
    !(rsp_live && ((q_full && !deq) || sh_empty)));
  a_issue_has_room: assert property (
    @(posedge clk) disable iff (rst) !(issue && sh_full));

endmodule

// File: tb/tb_mig_fetch_unit.sv
// Randomized and directed bench for mig_fetch_unit against a
// queue-level reference model with an in-order variable-latency memory.
module tb_mig_fetch_unit;
  import mig_fetch_pkg::*;

  localparam int AW = 32;
  localparam int QD = 4;
  typedef logic [AW-3:0] pc_t;

  typedef struct { pc_t addr; bit keep; } req_t;
  typedef struct { logic [31:0] insn; pc_t pc; } ent_t;
  typedef struct { pc_t addr; int due; } mreq_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  pc_t  rst_pc = '0;
  logic fetch_en = 1'b0;
  logic redirect_valid = 1'b0;
  pc_t  redirect_pc = '0;

  always #5 clk = ~clk;

  mig_fetch_if #(.ADDR_WIDTH(AW)) bus ();

  mig_fetch_unit #(
    .ADDR_WIDTH  (AW),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rst_pc         (rst_pc),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  req_t  outq[$];
  ent_t  iq[$];
  mreq_t memq[$];
  pc_t   m_pc;
  bit    m_boot;
  int    cyc;
  int    last_due;
  int    n_chk = 0;
  int    n_err = 0;

  bit rnd = 0;
  int p_ready, p_fen, p_redir;
  int lat_min = 1, lat_max = 1;

  logic obs_en[64];
  pc_t  obs_addr[64];
  logic obs_valid[64];
  pc_t  obs_pc[64];

  function automatic logic [31:0] insn_of(pc_t a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (outq[i]) if (outq[i].keep) n++;
    return n;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, compare at +1, advance model.
  task automatic cycle();
    bit   vld, exp_en;
    ent_t h;
    req_t r;
    int   d;
    if (rnd) begin
      bus.dec_ready  = ($urandom_range(99) < p_ready);
      fetch_en       = ($urandom_range(99) < p_fen);
      redirect_valid = ($urandom_range(99) < p_redir);
      redirect_pc    = pc_t'($urandom);
    end
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = insn_of(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = $urandom;
    end
    #1;
    vld    = (iq.size() > 0);
    exp_en = !m_boot && fetch_en && !redirect_valid
          && (iq.size() + live_cnt() < QD);
    if (vld) h = iq[0];
    else     h = '{32'd0, '0};
    chk("mem_rd_en", bus.mem_rd_en, exp_en);
    chk("mem_rd_addr", bus.mem_rd_addr, m_pc);
    chk("dec_valid", bus.dec_valid, vld);
    chk("dec_insn", bus.dec_insn, h.insn);
    chk("dec_pc", bus.dec_pc, h.pc);
    if (cyc < 64) begin
      obs_en[cyc]    = bus.mem_rd_en;
      obs_addr[cyc]  = bus.mem_rd_addr;
      obs_valid[cyc] = bus.dec_valid;
      obs_pc[cyc]    = bus.dec_pc;
    end
    if (bus.mem_rd_en) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      memq.push_back('{bus.mem_rd_addr, d});
      last_due = d;
    end
    if (m_boot) begin
      m_boot = 0;
    end else begin
      if (vld && bus.dec_ready) void'(iq.pop_front());
      if (bus.mem_rd_valid && outq.size() > 0) begin
        r = outq.pop_front();
        if (r.keep) iq.push_back('{bus.mem_rd_data, r.addr});
      end
      if (redirect_valid) begin
        iq.delete();
        foreach (outq[i]) outq[i].keep = 0;
        m_pc = redirect_pc;
      end else if (exp_en) begin
        outq.push_back('{m_pc, 1'b1});
        m_pc = m_pc + 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_to(pc_t pc);
    rst_pc           = pc;
    rst              = 1'b1;
    fetch_en         = 1'b0;
    redirect_valid   = 1'b0;
    bus.dec_ready    = 1'b0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    outq.delete();
    iq.delete();
    memq.delete();
    m_pc     = pc;
    m_boot   = 1;
    last_due = -1;
    @(negedge clk);
    #1;
    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_mem_rd_addr", bus.mem_rd_addr, pc);
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_dec_insn", bus.dec_insn, 0);
    chk("rst_dec_pc", bus.dec_pc, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int kn[6][5] = '{
    '{100, 100,  0, 1, 1},
    '{ 50,  90,  5, 1, 3},
    '{ 20,  70,  3, 2, 4},
    '{ 90, 100,  8, 1, 2},
    '{ 70,  50, 10, 1, 4},
    '{100, 100,  2, 3, 3}
  };

  initial begin
    int n;
    @(negedge clk);

    // streaming from 0x100 with 1-cycle memory
    reset_to(30'h100);
    lat_min = 1; lat_max = 1;
    fetch_en = 1; bus.dec_ready = 1;
    run(8);
    chk("t1_boot_no_issue", obs_en[0], 0);
    chk("t1_first_en", obs_en[1], 1);
    chk("t1_first_addr", obs_addr[1], 30'h100);
    chk("t1_second_addr", obs_addr[2], 30'h101);
    chk("t1_no_early_valid", obs_valid[2], 0);
    chk("t1_pc3", obs_pc[3], 30'h100);
    chk("t1_pc4", obs_pc[4], 30'h101);
    chk("t1_pc5", obs_pc[5], 30'h102);

    // back-pressure: exactly QD requests then stall
    reset_to(30'h40);
    fetch_en = 1; bus.dec_ready = 0;
    run(12);
    n = 0;
    for (int i = 0; i < 12; i++) n += int'(obs_en[i]);
    chk("t2_issue_count", n, 4);
    bus.dec_ready = 1;
    run(8);
    chk("t2_drain0", obs_pc[12], 30'h40);
    chk("t2_drain3", obs_pc[15], 30'h43);
    chk("t2_resume_en", obs_en[13], 1);
    chk("t2_resume_addr", obs_addr[13], 30'h44);

    // redirect with two requests in flight, latency 3
    reset_to(30'h100);
    lat_min = 3; lat_max = 3;
    fetch_en = 1; bus.dec_ready = 1;
    for (int i = 0; i < 14; i++) begin
      redirect_valid = (i == 3);
      redirect_pc    = 30'h200;
      cycle();
    end
    chk("t3_no_issue_redir", obs_en[3], 0);
    chk("t3_new_addr", obs_addr[4], 30'h200);
    n = 0;
    for (int i = 4; i < 8; i++) n += int'(obs_valid[i]);
    chk("t3_flushed", n, 0);
    chk("t3_first_pc", obs_pc[8], 30'h200);

    // redirect together with a response and a decode handshake
    reset_to(30'h100);
    lat_min = 2; lat_max = 2;
    fetch_en = 1; bus.dec_ready = 1;
    for (int i = 0; i < 12; i++) begin
      redirect_valid = (i == 5);
      redirect_pc    = 30'h300;
      cycle();
    end
    chk("t4_hs_pc", obs_pc[5], 30'h101);
    chk("t4_restart_addr", obs_addr[6], 30'h300);
    n = 0;
    for (int i = 6; i < 9; i++) n += int'(obs_valid[i]);
    chk("t4_stale_dropped", n, 0);
    chk("t4_first_pc", obs_pc[9], 30'h300);

    // PC wrap and fetch_en gating
    reset_to('1);
    lat_min = 1; lat_max = 1;
    fetch_en = 1; bus.dec_ready = 1;
    run(6);
    fetch_en = 0;
    run(10);
    chk("t5_top_addr", obs_addr[1], 30'h3FFF_FFFF);
    chk("t5_wrap_addr", obs_addr[2], 0);
    chk("t5_wrap_en", obs_en[2], 1);
    n = 0;
    for (int i = 6; i < 16; i++) n += int'(obs_en[i]);
    chk("t5_gated", n, 0);
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(obs_valid[i]);
    chk("t5_drained", n, 5);

    // asynchronous reset with three queued entries
    reset_to(30'h80);
    fetch_en = 1; bus.dec_ready = 0;
    run(4);
    fetch_en = 0;
    run(3);
    chk("t6_queued", obs_valid[6], 1);
    fetch_en = 1;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", bus.dec_valid, 0);
    chk("t6_async_en", bus.mem_rd_en, 0);
    chk("t6_async_addr", bus.mem_rd_addr, 30'h80);
    reset_to(30'h80);
    fetch_en = 1; bus.dec_ready = 1;
    run(6);
    chk("t6_restart_addr", obs_addr[1], 30'h80);
    chk("t6_restart_pc", obs_pc[3], 30'h80);

    // randomized phases
    rnd = 1;
    for (int p = 0; p < 6; p++) begin
      reset_to((p == 3) ? 30'h3FFF_FFFD : pc_t'($urandom));
      p_ready = kn[p][0];
      p_fen   = kn[p][1];
      p_redir = kn[p][2];
      lat_min = kn[p][3];
      lat_max = kn[p][4];
      run(600);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
